envelope_follower: RTL and testbench
====================================

Name: envelope_follower

Overview:
- Analysis-side counterpart to the noise/AR voice chain: consumes a sample stream already shaped by an AR envelope and recovers its amplitude envelope and a gate signal.
- Sits on the sample clock after a voice or mixer output.
- Used for sidechain effects, voice-activity indication and driving retriggers.
- Rise and fall rates are programmable, and the gate detector has a threshold, hysteresis and a hold counter.

Parameters:
- BITDEPTH, 14, width of the input sample, the level output and the threshold.
- BITFRACTION, 6, fractional bits in the internal level accumulator.
- HOLDBITS, 8, width of the gate hold counter and the hold_samples input.

Ports:
- sample_clock  in  1  sample-rate clock; all state advances on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  BITDEPTH  unsigned sample magnitude, one per clock.
- envelope_attack  in  8  rise step, in accumulator fractional LSBs per sample; 0 = instant.
- envelope_decay  in  8  fall step, in accumulator fractional LSBs per sample; 0 = instant.
- threshold  in  BITDEPTH  gate open level.
- hysteresis  in  BITDEPTH  gate closes below threshold minus hysteresis.
- hold_samples  in  HOLDBITS  samples the level must stay below the close level before the gate drops.
- level  out  BITDEPTH  recovered envelope.
- gate  out  1  envelope-present indication.
- gate_onset  out  1  one-cycle pulse on gate open.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - acc = 0, level = 0, gate = 0, gate_onset = 0, FSM = CLOSED, hold counter = 0.
- Accumulator:
  - acc is BITDEPTH+BITFRACTION bits wide and unsigned.
  - target = in << BITFRACTION.
  - level = acc[top BITDEPTH bits], registered; there is no combinational path from in to level.
- Each edge:
  - If target > acc:
    - envelope_attack = 0: acc = target.
    - Otherwise: acc = min(acc + envelope_attack, target).
  - If target < acc:
    - envelope_decay = 0: acc = target.
    - Otherwise: acc = max(acc - envelope_decay, target).
  - If target = acc: acc holds.
  - The add and subtract are computed one bit wider, so acc never wraps and never overshoots target.
- Latency:
  - A step on in is reflected in level one edge later when the rate is 0.
  - gate responds one further edge later; the FSM compares the registered level.
- close_level = threshold - hysteresis, saturating at 0.
- FSM states, with transitions evaluated each edge on the registered level:
  - CLOSED:
    - level >= threshold -> OPEN, with gate_onset = 1 for exactly that cycle.
  - OPEN:
    - level < close_level: if hold_samples = 0 -> CLOSED; otherwise -> HOLD with counter = 1.
  - HOLD:
    - level >= close_level -> OPEN; the counter is cleared and no onset pulse is generated.
    - Else if counter = hold_samples -> CLOSED.
    - Else the counter increments.
- gate = 1 in OPEN and HOLD, 0 in CLOSED; registered.
- Boundaries:
  - threshold = 0: the gate opens on the first post-reset edge, with a single onset pulse, and stays open.
  - hysteresis > threshold: close_level = 0, so the gate never closes once open.
  - Control inputs change freely at any time and take effect on the next edge.
  - Reset mid-HOLD returns to CLOSED with no pulse.
  - Full-scale input with rate 255 saturates cleanly at acc = target.

Test Plan:
- Reset / instant attack: assert rst mid-run -> level = 0, gate = 0 immediately. Release, apply in = 0x2000 with attack = 0 -> level = 0x2000 after 1 edge.
- Linear attack: attack = 64, in = 0x0010 from level 0 -> level increments by 1 per edge and reaches 0x0010 after 16 edges, then holds (no overshoot).
- Linear decay: from level 0x0100, in = 0, decay = 128 -> level falls 2 per edge and reaches 0 after 128 edges. decay = 0 -> level reaches 0 in 1 edge.
- Gate open: threshold = 0x0800, hysteresis = 0x0100, in steps 0 -> 0x1000 with attack = 0 -> gate rises on edge 2 after the step. gate_onset is high for that single cycle only.
- Hysteresis and hold: after the gate is open, in = 0x0780 -> gate stays 1. in = 0x0600 with hold_samples = 4 -> gate drops exactly 4 edges after entering HOLD. A single sample back to 0x0780 during HOLD returns to OPEN with no onset pulse.
- Saturation / edge cases: in = 0x3FFF with attack = 255 -> acc settles at 0xFFFC0 without wrap. threshold = 0 -> one onset pulse after reset, then gate stays high.

Source files
------------

// File: rtl/envelope_follower.sv
// Envelope follower: slews an internal fixed-point accumulator toward each input sample
// at programmable rise/fall rates and derives a gate with threshold, hysteresis and hold.
module envelope_follower #(
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int HOLDBITS    = 8
) (
    input  logic                sample_clock,
    input  logic                rst,
    input  logic [BITDEPTH-1:0] in,
    input  logic [7:0]          envelope_attack,
    input  logic [7:0]          envelope_decay,
    input  logic [BITDEPTH-1:0] threshold,
    input  logic [BITDEPTH-1:0] hysteresis,
    input  logic [HOLDBITS-1:0] hold_samples,
    output logic [BITDEPTH-1:0] level,
    output logic                gate,
    output logic                gate_onset
);

    localparam int ACCW = BITDEPTH + BITFRACTION;

    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [ACCW-1:0]     acc_q, acc_d;
    logic [ACCW-1:0]     target_s;
    logic [ACCW:0]       sum_s, diff_s;
    logic [BITDEPTH-1:0] close_level_s;
    logic [1:0]          state_q, state_d;
    logic [HOLDBITS-1:0] cnt_q, cnt_d;
    logic                gate_q, gate_d;
    logic                onset_q, onset_d;

    assign target_s = {in, {BITFRACTION{1'b0}}};
    // One extra bit keeps the carry/borrow visible so the slew can clamp instead of wrapping.
    assign sum_s    = {1'b0, acc_q} + {{(ACCW-7){1'b0}}, envelope_attack};
    assign diff_s   = {1'b0, acc_q} - {{(ACCW-7){1'b0}}, envelope_decay};

    assign close_level_s = (threshold >= hysteresis) ? (threshold - hysteresis)
                                                     : {BITDEPTH{1'b0}};

    assign level      = acc_q[ACCW-1 -: BITDEPTH];
    assign gate       = gate_q;
    assign gate_onset = onset_q;

    // Accumulator slew toward the target, clamped so it never overshoots.
    always_comb begin
        acc_d = acc_q;
        if (target_s > acc_q) begin
            if (envelope_attack == 8'd0) begin
                acc_d = target_s;
            end else if (sum_s > {1'b0, target_s}) begin
                acc_d = target_s;
            end else begin
                acc_d = sum_s[ACCW-1:0];
            end
        end else if (target_s < acc_q) begin
            if (envelope_decay == 8'd0) begin
                acc_d = target_s;
            end else if (diff_s[ACCW] || (diff_s[ACCW-1:0] < target_s)) begin
                acc_d = target_s;
            end else begin
                acc_d = diff_s[ACCW-1:0];
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Gate FSM, evaluated on the registered level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        onset_d = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if (level >= threshold) begin
                    state_d = ST_OPEN;
                    onset_d = 1'b1;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            ST_OPEN: begin
                if (level < close_level_s) begin
                    if (hold_samples == {HOLDBITS{1'b0}}) begin
                        state_d = ST_CLOSED;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = {{(HOLDBITS-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_HOLD: begin
                if (level >= close_level_s) begin
                    state_d = ST_OPEN;
                    cnt_d   = {HOLDBITS{1'b0}};
                end else if (cnt_q == hold_samples) begin
                    state_d = ST_CLOSED;
                    cnt_d   = {HOLDBITS{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(HOLDBITS-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_CLOSED;
                cnt_d   = {HOLDBITS{1'b0}};
            end
        endcase
        gate_d = (state_d != ST_CLOSED);
    end

    // State registers.
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            acc_q   <= {ACCW{1'b0}};
            state_q <= ST_CLOSED;
            cnt_q   <= {HOLDBITS{1'b0}};
            gate_q  <= 1'b0;
            onset_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            onset_q <= onset_d;
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench for envelope_follower: directed scenarios plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_envelope_follower;

    localparam int BD = 14;
    localparam int BF = 6;

    logic          clk = 1'b0;
    logic          rst_s;
    logic [13:0]   in_s, thr_s, hys_s, level_s;
    logic [7:0]    atk_s, dec_s, hold_s;
    logic          gate_s, onset_s;

    typedef struct { int lvl; int gate; int onset; } exp_t;
    exp_t sb[$];

    int nvec  = 0;
    int nfail = 0;

    // Control settings applied by the driver each cycle
    int c_in = 0, c_atk = 0, c_dec = 0, c_thr = 16383, c_hys = 0, c_hold = 0;

    // Reference model state
    int m_acc = 0, m_st = 0, m_cnt = 0, m_gate = 0, m_onset = 0;

    always #5 clk = ~clk;

    envelope_follower #(.BITDEPTH(14), .BITFRACTION(6), .HOLDBITS(8)) dut (
        .sample_clock    (clk),
        .rst             (rst_s),
        .in              (in_s),
        .envelope_attack (atk_s),
        .envelope_decay  (dec_s),
        .threshold       (thr_s),
        .hysteresis      (hys_s),
        .hold_samples    (hold_s),
        .level           (level_s),
        .gate            (gate_s),
        .gate_onset      (onset_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: state after one rising edge given the current inputs.
    function automatic void model_step(input bit r);
        int lvl, close_lvl, tgt;
        if (r) begin
            m_acc = 0; m_st = 0; m_cnt = 0; m_gate = 0; m_onset = 0;
            return;
        end
        lvl       = m_acc / 64;
        close_lvl = (c_thr > c_hys) ? c_thr - c_hys : 0;
        m_onset   = 0;
        if (m_st == 0) begin
            if (lvl >= c_thr) begin m_st = 1; m_onset = 1; end
        end else if (m_st == 1) begin
            if (lvl < close_lvl) begin
                if (c_hold == 0) m_st = 0;
                else begin m_st = 2; m_cnt = 1; end
            end
        end else begin
            if (lvl >= close_lvl) begin m_st = 1; m_cnt = 0; end
            else if (m_cnt == c_hold) begin m_st = 0; m_cnt = 0; end
            else m_cnt = (m_cnt + 1) % 256;
        end
        m_gate = (m_st != 0) ? 1 : 0;
        tgt = c_in * 64;
        if (tgt > m_acc) m_acc = (c_atk == 0 || m_acc + c_atk > tgt) ? tgt : m_acc + c_atk;
        else if (tgt < m_acc) m_acc = (c_dec == 0 || m_acc - c_dec < tgt) ? tgt : m_acc - c_dec;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the expected response.
    task automatic apply(input bit r);
        exp_t e;
        @(negedge clk);
        in_s   = c_in[13:0];
        atk_s  = c_atk[7:0];
        dec_s  = c_dec[7:0];
        thr_s  = c_thr[13:0];
        hys_s  = c_hys[13:0];
        hold_s = c_hold[7:0];
        rst_s  = r;
        model_step(r);
        e.lvl = m_acc / 64; e.gate = m_gate; e.onset = m_onset;
        sb.push_back(e);
        if (r) begin
            #1;
            chk("async_rst_level", int'(level_s), 0);
            chk("async_rst_gate",  int'(gate_s), 0);
            chk("async_rst_onset", int'(onset_s), 0);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) apply(1'b0);
    endtask

    // Direct check after the next rising edge; a negative expectation skips that field.
    task automatic expect_now(input string name, input int lvl, input int g, input int o);
        @(posedge clk);
        #2;
        if (lvl >= 0) chk({name, "_level"}, int'(level_s), lvl);
        if (g >= 0)   chk({name, "_gate"},  int'(gate_s),  g);
        if (o >= 0)   chk({name, "_onset"}, int'(onset_s), o);
    endtask

    // Monitor: every rising edge the DUT presents a new sample; pop and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_level", int'(level_s), e.lvl);
            chk("sb_gate",  int'(gate_s),  e.gate);
            chk("sb_onset", int'(onset_s), e.onset);
        end
    end

    initial begin
        rst_s = 1'b1; in_s = '0; atk_s = '0; dec_s = '0;
        thr_s = 14'h3FFF; hys_s = '0; hold_s = '0;
        apply(1'b1); apply(1'b1);

        // Run, then reset mid-run; then instant attack
        c_in = 16'h1234; c_atk = 20; step(10);
        apply(1'b1);
        c_in = 16'h2000; c_atk = 0; step(1);
        expect_now("instant_attack", 16'h2000, 0, 0);

        // Linear attack with no overshoot
        c_in = 0; c_dec = 0; step(1);
        c_in = 16'h0010; c_atk = 64; step(15);
        expect_now("attack_15", 15, -1, -1);
        step(1);
        expect_now("attack_16", 16, -1, -1);
        step(3);
        expect_now("attack_hold", 16, -1, -1);

        // Linear decay and instant decay
        c_in = 16'h0100; c_atk = 0; step(1);
        c_in = 0; c_dec = 128; step(64);
        expect_now("decay_64", 16'h0080, -1, -1);
        step(64);
        expect_now("decay_128", 0, -1, -1);
        c_in = 16'h0100; step(1);
        c_in = 0; c_dec = 0; step(1);
        expect_now("instant_decay", 0, -1, -1);

        // Gate open latency and single onset pulse
        c_thr = 16'h0800; c_hys = 16'h0100; c_hold = 4; step(3);
        c_in = 16'h1000; step(1);
        expect_now("gate_edge1", 16'h1000, 0, 0);
        step(1);
        expect_now("gate_edge2", -1, 1, 1);
        step(1);
        expect_now("gate_edge3", -1, 1, 0);

        // Hysteresis keeps gate open; hold delays close by exactly hold_samples
        c_in = 16'h0780; step(5);
        expect_now("hyst_open", -1, 1, 0);
        c_in = 16'h0600; step(2);
        step(3);
        expect_now("hold_3", -1, 1, 0);
        step(1);
        expect_now("hold_close", -1, 0, 0);

        // Return from HOLD to OPEN without an onset pulse
        c_in = 16'h1000; step(2);
        c_in = 16'h0600; step(2);
        c_in = 16'h0780; step(2);
        expect_now("hold_reopen", -1, 1, 0);
        step(6);

        // Full-scale saturation with rate 255
        c_thr = 16'h3FFF; c_hys = 0; c_in = 0; c_atk = 0; step(3);
        c_in = 16'h3FFF; c_atk = 255; step(4111);
        expect_now("sat_4111", 16'h3FFB, -1, -1);
        step(1);
        expect_now("sat_4112", 16'h3FFF, -1, -1);
        step(5);
        expect_now("sat_settled", 16'h3FFF, -1, -1);

        // threshold = 0: one onset after reset, then stays open
        c_in = 0; c_atk = 0; c_dec = 0; c_thr = 0; c_hys = 0;
        apply(1'b1);
        step(1);
        expect_now("thr0_first", -1, 1, 1);
        step(10);
        expect_now("thr0_stay", -1, 1, 0);

        // hysteresis > threshold: never closes
        apply(1'b1);
        c_thr = 16'h0100; c_hys = 16'h0200; c_hold = 0; c_in = 16'h0200; step(3);
        c_in = 0; step(20);
        expect_now("close0_stay", -1, 1, 0);

        // Reset mid-HOLD
        apply(1'b1);
        c_hys = 16'h0010; c_hold = 50; c_in = 16'h0200; step(3);
        c_in = 0; step(5);
        apply(1'b1);
        step(1);
        expect_now("post_hold_rst", 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) begin
                c_atk  = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 255));
                c_dec  = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 255));
                c_thr  = ($urandom % 8 == 0) ? 0 : int'($urandom_range(0, 16383));
                c_hys  = int'($urandom_range(0, 4096));
            end
            if ($urandom % 16 == 0) c_hold = int'($urandom_range(0, 6));
            if ($urandom % 6 == 0)  c_in   = int'($urandom_range(0, 16383));
            apply(($urandom % 400 == 0) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
